peaks_sched: RTL
================

Name: peaks_sched

Overview:
Frame scheduler and result buffer for the peaks datapath. Accepts one FFT magnitude frame at a time from the FFT core over valid/ready, registers it, and issues a single-cycle valid_in to peaks. It waits a fixed latency, then captures the PEAKS amplitude/frequency results. Each result is stamped with a frame time index and pushed into a small show-ahead FIFO that the HPS/Avalon side drains.

Parameters:
PEAKS_LATENCY, 4, cycles from peaks valid_in until peaks outputs are stable (>=1)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
TIME_WIDTH, 16, frame time index width
DROP_WIDTH, 8, saturating drop counter width

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  scheduler run enable
fft_valid  in  1  frame available from FFT
fft_ready  out  1  scheduler accepts frame
fft_frame  in  FREQS x INPUT_AMPL_WIDTH signed  frame magnitudes
pk_clear  out  1  one-cycle clear pulse to peaks history
pk_valid_in  out  1  to peaks valid_in
pk_fft_in  out  FREQS x INPUT_AMPL_WIDTH signed  registered frame to peaks fft_in
pk_ampl  in  PEAKS x FINAL_AMPL_WIDTH signed  from peaks amplitudes_out
pk_freq  in  PEAKS x FREQ_WIDTH  from peaks freqs_out
rd_req  in  1  pop head entry
rd_valid  out  1  FIFO non-empty
rd_time  out  TIME_WIDTH  head time index
rd_ampl  out  PEAKS x FINAL_AMPL_WIDTH signed  head amplitudes
rd_freq  out  PEAKS x FREQ_WIDTH  head frequencies
fifo_level  out  clog2(FIFO_DEPTH)+1  occupancy
drop_count  out  DROP_WIDTH  frames lost to full FIFO

Behaviour:
- Reset (reset=0, async): state=IDLE, armed=1, time_idx=0, drop_count=0, FIFO empty.
- Reset values of outputs: pk_valid_in=0, pk_clear=0, pk_fft_in all 0, fft_ready=0, rd_valid=0, fifo_level=0, rd_* = 0.
- FSM states: IDLE, CLEAR, ISSUE, WAIT, CAPTURE.
- IDLE:
  - enable=1 and armed=1 -> CLEAR.
  - otherwise fft_ready = enable (combinational from state).
  - fft_valid & fft_ready -> latch fft_frame into pk_fft_in, go to ISSUE.
  - enable=0 -> set armed=1.
- CLEAR: pk_clear=1 for exactly one cycle, time_idx<=0, armed<=0, fft_ready=0 -> IDLE.
- ISSUE (cycle k): pk_valid_in=1 for exactly one cycle, wait counter <= PEAKS_LATENCY-1 -> WAIT.
- WAIT: occupies cycles k+1..k+PEAKS_LATENCY; counter decrements; leaves to CAPTURE when counter=0.
- CAPTURE (cycle k+PEAKS_LATENCY+1):
  - samples pk_ampl/pk_freq.
  - FIFO not full -> push {time_idx, ampl, freq}; otherwise drop_count++ (saturates at all-ones).
  - time_idx increments either way, wrapping mod 2^TIME_WIDTH.
  - -> IDLE.
- fft_ready is 0 in every state except IDLE. Minimum frame period is PEAKS_LATENCY+3 cycles; the source holds fft_frame/fft_valid until accepted.
- pk_fft_in holds its value until the next acceptance.
- FIFO (show-ahead):
  - rd_* reflect the head entry whenever rd_valid=1.
  - rd_req with rd_valid=1 pops; rd_req while empty is ignored.
  - Push plus pop in the same cycle: both occur, level unchanged.
  - Full test uses pre-pop occupancy: a push while full is dropped even if a pop occurs in the same cycle.
- enable dropped mid-frame: the frame completes through CAPTURE, then the FSM stays in IDLE with fft_ready=0. The next enable rise produces CLEAR before any frame is accepted.
- After reset, the first enable=1 always produces a CLEAR cycle.
- Reset mid-operation aborts immediately: in-flight frame and FIFO contents are lost.

Decomposition:
- peaks_pkg holds FREQS, PEAKS, INPUT_AMPL_WIDTH, FINAL_AMPL_WIDTH, FREQ_WIDTH, the sched_state_t enum and the result-entry struct {time, ampl[PEAKS], freq[PEAKS]}.
- One sub-module: peaks_result_fifo (parameterised depth, show-ahead, full/empty/level).
- FSM and counters stay in peaks_sched.

Test Plan:
- Reset then enable=1 -> pk_clear high exactly one cycle, fft_ready rises the next cycle, time_idx=0, rd_valid=0.
- Frame with fft_frame[8]=6, rest 0, accepted at cycle a -> pk_valid_in high only at a+1 with pk_fft_in[8]=6. Stub peaks drives ampl/freq at a+5. Expect rd_valid at a+7 with rd_time=0 and the stubbed values; fft_ready low from a+1 through a+6.
- Back-to-back frames with fft_valid held high -> acceptances exactly 7 cycles apart; rd_time sequence 0,1,2.
- Five frames with no rd_req -> fifo_level=4, drop_count=1, next accepted frame stamped time 5. Four pops return times 0,1,2,3.
- FIFO full, rd_req asserted in the CAPTURE cycle -> head popped, new result dropped, drop_count increments, fifo_level=3.
- enable deasserted during WAIT -> frame still captured, fft_ready stays 0. Re-enable -> one pk_clear pulse, next frame stamped time 0. Async reset asserted during WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/peaks_pkg.sv
`default_nettype none
// ============================================================================
// peaks_pkg : shared widths, scheduler state encoding and result-entry layout
// Revision 1.0 - initial release
// ============================================================================
package peaks_pkg;

    localparam int FREQS            = 16;
    localparam int PEAKS            = 2;
    localparam int INPUT_AMPL_WIDTH = 16;
    localparam int FINAL_AMPL_WIDTH = 18;
    localparam int FREQ_WIDTH       = 4;
    // Time stamps are stored at this width; the scheduler exposes the low TIME_WIDTH bits
    localparam int TIME_WIDTH_MAX   = 32;

    typedef logic signed [INPUT_AMPL_WIDTH-1:0] in_ampl_t;
    typedef logic signed [FINAL_AMPL_WIDTH-1:0] final_ampl_t;
    typedef logic        [FREQ_WIDTH-1:0]       freq_t;

    typedef in_ampl_t    [FREQS-1:0] frame_t;
    typedef final_ampl_t [PEAKS-1:0] ampl_vec_t;
    typedef freq_t       [PEAKS-1:0] freq_vec_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [TIME_WIDTH_MAX-1:0] tstamp;
        ampl_vec_t                 ampl;
        freq_vec_t                 freq;
    } result_entry_t;

endpackage
`default_nettype wire

// File: rtl/peaks_result_fifo.sv
`default_nettype none
// ============================================================================
// peaks_result_fifo : show-ahead result FIFO with full/empty/level flags
// Revision 1.0 - initial release
// ============================================================================
module peaks_result_fifo
    import peaks_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  result_entry_t            push_data,
    input  logic                     pop,
    output result_entry_t            head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    result_entry_t          r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr;
    logic [ADDR_WIDTH:0]    r_level;
    logic                   w_do_push;
    logic                   w_do_pop;

    // Full is judged on pre-pop occupancy, so a push into a full FIFO is lost even with a pop
    assign empty     = (r_level == '0);
    assign full      = (r_level == (ADDR_WIDTH+1)'(DEPTH));
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign level     = r_level;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (ADDR_WIDTH+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_WIDTH+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/peaks_sched.sv
`default_nettype none
// ============================================================================
// peaks_sched : frame scheduler for the peaks core plus time-stamped result FIFO
// Revision 1.0 - initial release
// ============================================================================
module peaks_sched
    import peaks_pkg::*;
#(
    parameter int PEAKS_LATENCY = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIME_WIDTH    = 16,
    parameter int DROP_WIDTH    = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          fft_valid,
    output logic                          fft_ready,
    input  frame_t                        fft_frame,
    output logic                          pk_clear,
    output logic                          pk_valid_in,
    output frame_t                        pk_fft_in,
    input  ampl_vec_t                     pk_ampl,
    input  freq_vec_t                     pk_freq,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic [TIME_WIDTH-1:0]         rd_time,
    output ampl_vec_t                     rd_ampl,
    output freq_vec_t                     rd_freq,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_WIDTH-1:0]         drop_count
);

    localparam int WAIT_WIDTH = $clog2(PEAKS_LATENCY + 1);

    sched_state_t            r_state;
    logic                    r_armed;
    logic [TIME_WIDTH-1:0]   r_time_idx;
    logic [DROP_WIDTH-1:0]   r_drop_count;
    logic [WAIT_WIDTH-1:0]   r_wait_cnt;
    logic                    r_pk_clear;
    logic                    r_pk_valid_in;
    frame_t                  r_pk_fft_in;

    logic                    w_fft_ready;
    logic                    w_push;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    result_entry_t           w_push_entry;
    result_entry_t           w_head;

    // A pending clear (armed) always wins over accepting a frame
    assign w_fft_ready = (r_state == S_IDLE) && enable && !r_armed;
    assign w_push      = (r_state == S_CAPTURE);

    assign w_push_entry.tstamp = TIME_WIDTH_MAX'(r_time_idx);
    assign w_push_entry.ampl   = pk_ampl;
    assign w_push_entry.freq   = pk_freq;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_armed       <= 1'b1;
            r_time_idx    <= '0;
            r_drop_count  <= '0;
            r_wait_cnt    <= '0;
            r_pk_clear    <= 1'b0;
            r_pk_valid_in <= 1'b0;
            r_pk_fft_in   <= '0;
        end else begin
            r_pk_clear    <= 1'b0;
            r_pk_valid_in <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!enable) begin
                        r_armed <= 1'b1;
                    end
                    if (enable && r_armed) begin
                        r_pk_clear <= 1'b1;
                        r_state    <= S_CLEAR;
                    end else if (fft_valid && w_fft_ready) begin
                        r_pk_fft_in   <= fft_frame;
                        r_pk_valid_in <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_CLEAR: begin
                    r_time_idx <= '0;
                    r_armed    <= 1'b0;
                    r_state    <= S_IDLE;
                end
                S_ISSUE: begin
                    r_wait_cnt <= WAIT_WIDTH'(PEAKS_LATENCY - 1);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_WIDTH'(1);
                    end
                end
                S_CAPTURE: begin
                    if (w_fifo_full && (r_drop_count != '1)) begin
                        r_drop_count <= r_drop_count + DROP_WIDTH'(1);
                    end
                    r_time_idx <= r_time_idx + TIME_WIDTH'(1);
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    peaks_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (rd_req),
        .head      (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (fifo_level)
    );

    assign fft_ready   = w_fft_ready;
    assign pk_clear    = r_pk_clear;
    assign pk_valid_in = r_pk_valid_in;
    assign pk_fft_in   = r_pk_fft_in;
    assign drop_count  = r_drop_count;
    assign rd_valid    = !w_fifo_empty;
    assign rd_time     = w_head.tstamp[TIME_WIDTH-1:0];
    assign rd_ampl     = w_head.ampl;
    assign rd_freq     = w_head.freq;

endmodule
`default_nettype wire
